pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline stage register for the 5-stage core, replacing the fixed per-stage enable registers between IF/ID, ID/EX, EX/MEM and MEM/WB. It carries a data payload plus a separate control field under a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered, so back-pressure does not ripple combinationally through the pipeline. It also provides synchronous flush (bubble insertion) and a saturating stall-cycle counter for performance measurement.

## Interface
- `DATA_W`, 64: payload width (operands, PC, immediate, register indices packed by the instantiating stage).
- `CTRL_W`, 8: control-field width (writeback, memread/memwrite, branch, jump, alusrc, aluop…).
- `PRESET_VAL`, 0: reset value of the payload registers.
- `CNT_W`, 16: stall-counter width.
- `clk`  in  1  clock.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous flush; empties the stage.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `in_valid`  in  1  upstream has an entry.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control field.
- `out_valid`  out  1  stage holds a valid entry.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  head payload.
- `out_ctrl`  out  CTRL_W  head control; forced to 0 when `out_valid`=0.
- `stall_cnt`  out  CNT_W  cycles with `out_valid` && !`out_ready`.

## Operation
- Storage:
  - Main entry (head) and skid entry, each holding DATA_W+CTRL_W bits.
  - 2-bit state: EMPTY (0 entries), MAIN (1 entry), SKID (2 entries).
- Derived outputs:
  - in_acc = `in_valid` && `in_ready`; out_acc = `out_valid` && `out_ready`.
  - `in_ready` = (state != SKID). `out_valid` = (state != EMPTY).
  - `out_data` = main payload. `out_ctrl` = main control, gated to 0 when the stage is empty.
- Transitions (no flush):
  - EMPTY: in_acc → MAIN, main ← input.
  - MAIN, in_acc && out_acc → MAIN, main ← input.
  - MAIN, in_acc only → SKID, skid ← input.
  - MAIN, out_acc only → EMPTY.
  - SKID: out_acc → MAIN, main ← skid. Input is ignored because `in_ready`=0.
- Flush:
  - `flush`=1 forces next state EMPTY regardless of handshakes.
  - A coincident in_acc is discarded.
  - A coincident out_acc still completes downstream in that cycle.
  - Payload registers keep their values; only validity is cleared.
- Payload registers load only on the listed transitions. Otherwise they hold.
- `stall_cnt`:
  - +1 per cycle with `out_valid` && !`out_ready`, saturating at 2^CNT_W−1.
  - `cnt_clr` has priority over increment.
  - `flush` does not affect the counter.
- Illegal state encoding (2'b11) → next state EMPTY.

## Timing
- Reset values:
  - State EMPTY, so `out_valid`=0, `in_ready`=1, `out_ctrl`=0.
  - `out_data`=PRESET_VAL, `stall_cnt`=0.
- Reset mid-operation drops both entries immediately (asynchronous).
- Latency: an entry accepted at edge N appears on `out_*` after edge N (one cycle) when the stage was EMPTY or drained in the same cycle.
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- `in_ready` falls the cycle after the second entry is captured. It rises the cycle after the head drains from SKID.
- No combinational path from `out_ready` to `in_ready`.
- Combinational paths:
  - `out_valid`/`out_data` depend only on registers.
  - `out_ctrl` gating is combinational from the state register.
- Order is strictly FIFO. An entry is never duplicated or lost except by `flush`/reset.

## Structure
- Shared package `pipe_pkg`:
  - State typedef `pipe_st_t`: ST_EMPTY=2'b00, ST_MAIN=2'b01, ST_SKID=2'b10.
  - Default CNT_W constant.
- Sub-module: payload entries use the codebase's `reg_arstn_en` with DATA_W+CTRL_W width, two instances (main, skid), with enables driven from the state machine.
- State machine and counter live in this module.

## Test plan
- Reset, then `in_valid`=1, `in_data`=0xA5, `in_ctrl`=0x3, `out_ready`=1 → cycle after accept `out_valid`=1, `out_data`=0xA5, `out_ctrl`=0x3. Then `in_valid`=0 → `out_valid`=0, `out_ctrl`=0.
- Stream 1,2,3,4 with `out_ready`=1 → outputs 1,2,3,4 on consecutive cycles, `in_ready` stays 1.
- Send 1,2,3 with `out_ready`=0 → 1 and 2 captured; `in_ready`=0 from the cycle after 2; 3 held upstream. Raise `out_ready` → outputs 1,2,3 in order, none lost.
- State SKID (entries 7,8), assert `flush` with `in_valid`=1 data 9 → next cycle `out_valid`=0, `in_ready`=1; 7/8/9 never appear downstream.
- Hold `out_valid`=1, `out_ready`=0 for 5 cycles → `stall_cnt`=5. Pulse `cnt_clr` → 0. With CNT_W=4 and 20 stall cycles → 15 (saturated).
- Drop `arst_n` in SKID state mid-clock → `out_valid`=0, `in_ready`=1, `out_data`=PRESET_VAL immediately, before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stages.
// State encoding and default counter width.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_MAIN  = 2'b01,
      ST_SKID  = 2'b10
   } pipe_st_t;

   localparam int PIPE_CNT_W = 16;

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low reset.
// Used for the payload entries of pipeline stages.
module reg_arstn_en #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic stage register with two-entry skid buffer,
// synchronous flush and saturating stall counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter int                CTRL_W     = 8,
   parameter logic [DATA_W-1:0] PRESET_VAL = '0,
   parameter int                CNT_W      = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              flush,
   input  logic              cnt_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int EW = DATA_W + CTRL_W;
   localparam logic [EW-1:0] ENT_RST = {PRESET_VAL, {CTRL_W{1'b0}}};

   pipe_st_t          state_q;
   pipe_st_t          state_d;
   logic              in_acc;
   logic              out_acc;
   logic              main_en;
   logic              skid_en;
   logic              main_from_skid;
   logic [EW-1:0]     in_ent;
   logic [EW-1:0]     main_d;
   logic [EW-1:0]     main_q;
   logic [EW-1:0]     skid_q;
   logic [CNT_W-1:0]  cnt_q;

   assign in_ready  = (state_q != ST_SKID);
   assign out_valid = (state_q != ST_EMPTY);
   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;
   assign in_ent    = {in_data, in_ctrl};
   assign main_d    = main_from_skid ? skid_q : in_ent;

   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_acc) begin
               state_d = ST_MAIN;
               main_en = 1'b1;
            end
         end
         ST_MAIN: begin
            if (in_acc && out_acc) begin
               main_en = 1'b1;
            end else if (in_acc) begin
               state_d = ST_SKID;
               skid_en = 1'b1;
            end else if (out_acc) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_acc) begin
               state_d        = ST_MAIN;
               main_en        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush drops validity only; payload stays put.
      if (flush) begin
         state_d = ST_EMPTY;
         main_en = 1'b0;
         skid_en = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= ST_EMPTY;
      else state_q <= state_d;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (out_valid && !out_ready
                   && cnt_q != {CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   reg_arstn_en #(.W(EW), .RST_VAL(ENT_RST)) u_main (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (main_en),
      .d      (main_d),
      .q      (main_q)
   );

   reg_arstn_en #(.W(EW), .RST_VAL(ENT_RST)) u_skid (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (skid_en),
      .d      (in_ent),
      .q      (skid_q)
   );

   assign out_data  = main_q[EW-1:CTRL_W];
   assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic.
// Second instance with CNT_W=4 covers counter saturation.
module tb_pipe_stage_elastic;

   localparam logic [63:0] PV = 64'hDEAD_BEEF;

   logic        clk;
   logic        arst_n;
   logic        flush;
   logic        cnt_clr;
   logic        in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic [15:0] stall_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [63:0] out_data4;
   logic [7:0]  out_ctrl4;
   logic [3:0]  stall_cnt4;

   int checks = 0;
   int errors = 0;

   pipe_stage_elastic #(
      .DATA_W(64), .CTRL_W(8), .PRESET_VAL(PV), .CNT_W(16)
   ) dut (
      .clk(clk), .arst_n(arst_n), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_elastic #(
      .DATA_W(64), .CTRL_W(8), .CNT_W(4)
   ) dut4 (
      .clk(clk), .arst_n(arst_n), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .out_ctrl(out_ctrl4),
      .stall_cnt(stall_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0; flush = 0; cnt_clr = 0;
      in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
      checks++; if (out_ctrl !== 8'h0) begin errors++;
         $display("FAIL rst_out_ctrl got %0h exp 0", out_ctrl); end
      checks++; if (out_data !== PV) begin errors++;
         $display("FAIL rst_out_data got %0h exp %0h", out_data, PV); end
      checks++; if (stall_cnt !== 16'h0) begin errors++;
         $display("FAIL rst_stall_cnt got %0h exp 0", stall_cnt); end
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      in_valid = 1; in_data = 64'hA5; in_ctrl = 8'h3; out_ready = 1;
      step();
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL single_valid got %0h exp 1", out_valid); end
      checks++; if (out_data !== 64'hA5) begin errors++;
         $display("FAIL single_data got %0h exp a5", out_data); end
      checks++; if (out_ctrl !== 8'h3) begin errors++;
         $display("FAIL single_ctrl got %0h exp 3", out_ctrl); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL single_drain_valid got %0h exp 0", out_valid); end
      checks++; if (out_ctrl !== 8'h0) begin errors++;
         $display("FAIL single_drain_ctrl got %0h exp 0", out_ctrl); end
   endtask

   task automatic test_stream();
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1; in_data = 64'(i); in_ctrl = 8'(i + 16);
         step();
         checks++; if (out_data !== 64'(i) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_data[%0d] got %0h v%0h exp %0h",
                     i, out_data, out_valid, i); end
         checks++; if (out_ctrl !== 8'(i + 16)) begin errors++;
            $display("FAIL stream_ctrl[%0d] got %0h exp %0h",
                     i, out_ctrl, i + 16); end
         checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL stream_in_ready[%0d] got %0h exp 1",
                     i, in_ready); end
      end
      in_valid = 0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL stream_end_valid got %0h exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      in_valid = 1; in_data = 64'd1; in_ctrl = 8'h1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_ready_after1 got %0h exp 1", in_ready); end
      in_data = 64'd2; in_ctrl = 8'h2;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL bp_ready_after2 got %0h exp 0", in_ready); end
      checks++; if (out_data !== 64'd1) begin errors++;
         $display("FAIL bp_head1 got %0h exp 1", out_data); end
      in_data = 64'd3; in_ctrl = 8'h3;
      step();
      checks++; if (in_ready !== 1'b0 || out_data !== 64'd1) begin
         errors++;
         $display("FAIL bp_hold got rdy %0h data %0h exp 0/1",
                  in_ready, out_data); end
      out_ready = 1;
      step();
      checks++; if (out_data !== 64'd2 || out_ctrl !== 8'h2) begin
         errors++;
         $display("FAIL bp_head2 got %0h/%0h exp 2/2",
                  out_data, out_ctrl); end
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_ready_rise got %0h exp 1", in_ready); end
      step();
      in_valid = 0;
      checks++; if (out_data !== 64'd3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_head3 got %0h v%0h exp 3",
                  out_data, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL bp_empty got %0h exp 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 0;
      in_valid = 1; in_data = 64'd7; in_ctrl = 8'h7;
      step();
      in_data = 64'd8; in_ctrl = 8'h8;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL fl_skid_ready got %0h exp 0", in_ready); end
      flush = 1; in_data = 64'd9; in_ctrl = 8'h9;
      step();
      flush = 0; in_valid = 0; out_ready = 1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL fl_after got v%0h r%0h exp 0/1",
                  out_valid, in_ready); end
      checks++; if (out_ctrl !== 8'h0) begin errors++;
         $display("FAIL fl_ctrl got %0h exp 0", out_ctrl); end
      checks++; if (out_data !== 64'd7) begin errors++;
         $display("FAIL fl_payload_kept got %0h exp 7", out_data); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL fl_quiet[%0d] got %0h exp 0", i, out_valid);
         end
      end
   endtask

   task automatic test_stall();
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      checks++; if (stall_cnt !== 16'd0) begin errors++;
         $display("FAIL st_clr0 got %0d exp 0", stall_cnt); end
      out_ready = 0;
      in_valid = 1; in_data = 64'h11; in_ctrl = 8'h1;
      step();
      in_valid = 0;
      repeat (5) step();
      checks++; if (stall_cnt !== 16'd5) begin errors++;
         $display("FAIL st_five got %0d exp 5", stall_cnt); end
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      checks++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
         errors++;
         $display("FAIL st_clr got %0d/%0d exp 0/0",
                  stall_cnt, stall_cnt4); end
      repeat (20) step();
      checks++; if (stall_cnt !== 16'd20) begin errors++;
         $display("FAIL st_twenty got %0d exp 20", stall_cnt); end
      checks++; if (stall_cnt4 !== 4'd15) begin errors++;
         $display("FAIL st_sat got %0d exp 15", stall_cnt4); end
      flush = 1;
      step();
      flush = 0;
      checks++; if (stall_cnt !== 16'd21 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL st_flush got %0d v%0h exp 21/0",
                  stall_cnt, out_valid); end
      step();
      checks++; if (stall_cnt !== 16'd21) begin errors++;
         $display("FAIL st_idle got %0d exp 21", stall_cnt); end
   endtask

   task automatic test_async_reset();
      out_ready = 0;
      in_valid = 1; in_data = 64'h55; in_ctrl = 8'h5;
      step();
      in_data = 64'h66; in_ctrl = 8'h6;
      step();
      in_valid = 0;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre got r%0h v%0h exp 0/1",
                  in_ready, out_valid); end
      #2;
      arst_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ar_flags got v%0h r%0h exp 0/1",
                  out_valid, in_ready); end
      checks++; if (out_data !== PV || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL ar_data got %0h cnt %0d exp %0h/0",
                  out_data, stall_cnt, PV); end
      step();
      arst_n = 1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL ar_post got %0h exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
